mem_fill: RTL and testbench

MEM_FILL -- requirements
Module: mem_fill

---
 rtl/mem_fill.sv | 131 +++++++++++++
 tb/tb_mem_fill.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_fill.sv
// Memory fill engine: writes cmd_count words of a fill value to consecutive arbiter addresses.
// Define MEM_FILL_PATTERN_EN to enable the incrementing-pattern mode (fill + word offset).
module mem_fill #(
  parameter int              ADDR_W = 17,
  parameter int              DATA_W = 32,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] WR_OP  = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cmd_rts_in,
  output logic              cmd_rtr_out,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_mode,
  output logic [ADDR_W-1:0] arb_addr,
  output logic [DATA_W-1:0] arb_wr_data,
  output logic              arb_rts_out,
  input  logic              arb_rtr_in,
  output logic [OP_W-1:0]   arb_op,
  output logic              busy,
  output logic              sftrst_
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_DONE = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [DATA_W-1:0]   r_fill;
  logic [DATA_W-1:0]   w_fill_data;
  logic                w_cmd_xfer;
  logic                w_arb_xfer;

`ifdef MEM_FILL_PATTERN_EN
  logic                r_mode;
  logic [ADDR_W:0]     r_offset;

  // Pattern offset and mode, tracked alongside the address counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_mode   <= 1'b0;
      r_offset <= CNT_ZERO;
    end else if (w_cmd_xfer) begin
      r_mode   <= cmd_mode;
      r_offset <= CNT_ZERO;
    end else if (w_arb_xfer) begin
      r_offset <= r_offset + CNT_ONE;
    end
  end

  assign w_fill_data = r_mode ? (r_fill + DATA_W'(r_offset)) : r_fill;
`else
  logic w_unused_mode;
  assign w_unused_mode = cmd_mode;
  assign w_fill_data   = r_fill;
`endif

  // Gating with rst_ keeps upstream from seeing a ready handshake while held in reset.
  assign w_cmd_xfer = cmd_rts_in && cmd_rtr_out;
  assign w_arb_xfer = arb_rts_out && arb_rtr_in;

  // Control FSM and address/count datapath.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= ST_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_remaining <= CNT_ZERO;
      r_fill      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_xfer) begin
            r_addr      <= cmd_start;
            r_remaining <= cmd_count;
            r_fill      <= cmd_data;
            r_state     <= (cmd_count == CNT_ZERO) ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_arb_xfer) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - CNT_ONE;
            if (r_remaining == CNT_ONE) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from the current state and datapath registers.
  always_comb begin
    cmd_rtr_out = 1'b0;
    arb_rts_out = 1'b0;
    arb_op      = {OP_W{1'b0}};
    arb_wr_data = {DATA_W{1'b0}};
    busy        = 1'b0;
    sftrst_     = 1'b1;
    case (r_state)
      ST_IDLE: cmd_rtr_out = rst_;
      ST_FILL: begin
        arb_rts_out = 1'b1;
        arb_op      = WR_OP;
        arb_wr_data = w_fill_data;
        busy        = 1'b1;
      end
      ST_DONE: begin
        busy    = 1'b1;
        sftrst_ = 1'b0;
      end
      default: cmd_rtr_out = 1'b0;
    endcase
  end

  assign arb_addr = r_addr;

endmodule

// File: tb/tb_mem_fill.sv
// Randomized self-checking bench for mem_fill against a per-command write-list model.
module tb_mem_fill;

  logic        clk = 1'b0;
  logic        rst_;
  logic        cmd_rts_in;
  logic        cmd_rtr_out;
  logic [16:0] cmd_start;
  logic [17:0] cmd_count;
  logic [31:0] cmd_data;
  logic        cmd_mode;
  logic [16:0] arb_addr;
  logic [31:0] arb_wr_data;
  logic        arb_rts_out;
  logic        arb_rtr_in;
  logic [3:0]  arb_op;
  logic        busy;
  logic        sftrst_;

  int n_checks = 0;
  int n_fail   = 0;

  mem_fill dut (
    .clk(clk), .rst_(rst_),
    .cmd_rts_in(cmd_rts_in), .cmd_rtr_out(cmd_rtr_out),
    .cmd_start(cmd_start), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_mode(cmd_mode),
    .arb_addr(arb_addr), .arb_wr_data(arb_wr_data), .arb_rts_out(arb_rts_out),
    .arb_rtr_in(arb_rtr_in), .arb_op(arb_op), .busy(busy), .sftrst_(sftrst_)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rtr_mode: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1,1
  task automatic run_cmd(input logic [16:0] start, input logic [17:0] count,
                         input logic [31:0] data, input logic mode, input int rtr_mode);
    logic [16:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [16:0] a;
    logic [31:0] d;
    bit   pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   idx = 0;
    int   pat_i = 0;
    int   fill_cycles = 0;
    int   budget;
    bit   done = 1'b0;
    bit   rtr;

    for (int i = 0; i < int'(count); i++) begin
      a = start + 17'(i);
      d = data;
`ifdef MEM_FILL_PATTERN_EN
      if (mode) d = data + 32'(i);
`endif
      exp_addr.push_back(a);
      exp_data.push_back(d);
    end
    budget = int'(count) * 20 + 20;

    check("cmd_rtr_idle", {63'd0, cmd_rtr_out}, 64'd1);
    cmd_start  = start;
    cmd_count  = count;
    cmd_data   = data;
    cmd_mode   = mode;
    cmd_rts_in = 1'b1;
    step();

    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      // Keep a stray command pending to confirm it is ignored while busy.
      cmd_rts_in = 1'($urandom_range(0, 1));
      cmd_start  = 17'($urandom);
      cmd_count  = 18'($urandom_range(1, 5));
      if (cyc == 0)
        check("first_resp", {63'd0, (count == 18'd0) ? ~sftrst_ : arb_rts_out}, 64'd1);
      if (arb_rts_out) begin
        check("fill_busy", {62'd0, busy, cmd_rtr_out}, 64'd2);
        check("fill_op", {60'd0, arb_op}, 64'hF);
        check("fill_sftrst", {63'd0, sftrst_}, 64'd1);
        if (idx < int'(count)) begin
          check("wr_addr", {47'd0, arb_addr}, {47'd0, exp_addr[idx]});
          check("wr_data", {32'd0, arb_wr_data}, {32'd0, exp_data[idx]});
        end else begin
          check("extra_write", 64'(idx), 64'(count) - 64'd1);
        end
        fill_cycles++;
        case (rtr_mode)
          0: rtr = 1'b1;
          1: rtr = 1'($urandom_range(0, 1));
          default: begin rtr = pat[pat_i % 5]; pat_i++; end
        endcase
        arb_rtr_in = rtr;
        if (rtr) idx++;
      end else if (!sftrst_) begin
        check("write_count", 64'(idx), 64'(count));
        check("done_outs", {58'd0, busy, cmd_rtr_out, arb_op}, {58'd0, 1'b1, 1'b0, 4'h0});
        done = 1'b1;
        cmd_rts_in = 1'b0;
        arb_rtr_in = 1'($urandom_range(0, 1));
      end else begin
        check("lost_fill", 64'd0, 64'd1);
        done = 1'b1;
        cmd_rts_in = 1'b0;
      end
      step();
    end
    if (!done) begin
      check("timeout", 64'd0, 64'd1);
      cmd_rts_in = 1'b0;
    end
    check("post_done", {60'd0, sftrst_, cmd_rtr_out, busy, arb_rts_out}, {60'd0, 4'b1100});
    if (rtr_mode == 0) check("throughput", 64'(fill_cycles), 64'(count));
  endtask

  task automatic reset_mid_fill();
    logic [16:0] start;
    bit          pulse = 1'b0;
    start = 17'($urandom);
    cmd_start = start; cmd_count = 18'd8; cmd_data = $urandom; cmd_mode = 1'b0;
    cmd_rts_in = 1'b1; arb_rtr_in = 1'b1;
    step();
    cmd_rts_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_pre_addr", {47'd0, arb_addr}, {47'd0, 17'(start + 17'(i))});
      step();
    end
    check("rst_pre_rts", {63'd0, arb_rts_out}, 64'd1);
    rst_ = 1'b0;
    cmd_rts_in = 1'b1;
    #1;
    check("rst_async", {57'd0, arb_rts_out, busy, sftrst_, arb_op}, {57'd0, 3'b001, 4'h0});
    step();
    step();
    check("rst_hold", {57'd0, arb_rts_out, busy, sftrst_, arb_op}, {57'd0, 3'b001, 4'h0});
    cmd_rts_in = 1'b0;
    rst_ = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!sftrst_ || arb_rts_out || arb_addr != 17'd0 || !cmd_rtr_out) pulse = 1'b1;
    end
    check("rst_after_idle", {63'd0, pulse}, 64'd0);
  endtask

  initial begin
    rst_ = 1'b0; cmd_rts_in = 1'b0; cmd_start = 17'd0; cmd_count = 18'd0;
    cmd_data = 32'd0; cmd_mode = 1'b0; arb_rtr_in = 1'b0;
    #2;
    check("reset_outs", {56'd0, arb_rts_out, busy, sftrst_, arb_op, cmd_rtr_out},
          {56'd0, 3'b001, 4'h0, 1'b0});
    step();
    step();
    rst_ = 1'b1;
    step();
    check("reset_addr", {47'd0, arb_addr}, 64'd0);

    run_cmd(17'h00010, 18'd4, 32'hDEADBEEF, 1'b0, 0);
    run_cmd(17'h1FFFE, 18'd3, 32'h12345678, 1'b0, 0);
    run_cmd(17'h00123, 18'd0, 32'hCAFEF00D, 1'b0, 0);
    run_cmd(17'h00200, 18'd3, 32'hA5A5A5A5, 1'b0, 2);
    run_cmd(17'h00300, 18'd3, 32'hFFFFFFFE, 1'b1, 0);
    run_cmd(17'h1FFFF, 18'd1, 32'h00000001, 1'b1, 1);
    for (int n = 0; n < 25; n++)
      run_cmd(17'($urandom), 18'($urandom_range(0, 12)), $urandom, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)));
    reset_mid_fill();
    run_cmd(17'h1FFFA, 18'd9, 32'h7FFFFFFF, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
